// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory responder.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH_WORDS = 256;
  localparam int unsigned IMEM_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        err;
  } imem_req_t;

  // Misaligned or beyond the last word; addresses never wrap.
  function automatic logic imem_addr_err(input logic [31:0] addr,
                                         input int unsigned depth_words);
    logic [31:0] word;
    word = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word >= depth_words);
  endfunction

endpackage

// File: rtl/imem_req_fifo.sv
// Two-entry in-order request FIFO with synchronous flush.
module imem_req_fifo
  import imem_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  imem_req_t push_data,
  input  logic      pop,
  input  logic      flush,
  output imem_req_t head,
  output logic      full,
  output logic      empty
);

  imem_req_t  slots [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  // Guard against pushing into a full FIFO or popping an empty one.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointer and occupancy bookkeeping; flush discards everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) slots[wr_ptr] <= push_data;
  end

  // Status and head-of-queue view.
  always_comb begin
    full  = (count == 2'd2);
    empty = (count == 2'd0);
    head  = slots[rd_ptr];
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: queued fetch requests, fixed wait
// states, held response until accepted, flush and preload port.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = IMEM_WAIT_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  input  logic                           flush,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_data,
  output logic [31:0]                    rsp_addr,
  output logic                           rsp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  imem_state_e state_q, state_d;
  logic [2:0]  cnt_q;
  imem_req_t   cur_q;
  imem_req_t   fifo_head;
  imem_req_t   push_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        ready_en_q;
  logic        push;
  logic        pop;
  logic        cnt_load;
  logic        cnt_dec;
  logic        rd_fire;
  logic [AW-1:0] rd_idx;

  // Acceptance: ready_en_q keeps req_ready low through reset and lets
  // it rise on the first edge after release.
  always_comb begin
    req_ready = ready_en_q && !fifo_full && !flush;
    push      = req_valid && req_ready;
    push_data = '{addr: req_addr, err: imem_addr_err(req_addr, DEPTH_WORDS)};
    rd_idx    = cur_q.addr[AW+1:2];
  end

  // Ready enable register, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  imem_req_fifo u_req_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and control decode; flush overrides all progress.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    rd_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rd_fire = 1'b1;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            cnt_load = 1'b1;
            state_d  = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      pop      = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      rd_fire  = 1'b0;
    end
  end

  // Wait-state counter and the request currently in service.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      cur_q <= '0;
    end else begin
      if (cnt_load)     cnt_q <= 3'(WAIT_CYCLES);
      else if (cnt_dec) cnt_q <= cnt_q - 3'd1;
      if (pop) cur_q <= fifo_head;
    end
  end

  // Program preload; writes in any state, never reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Response registers: captured at wait exit (old data if a load hits
  // the same word that edge), held until the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (rd_fire) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= cur_q.addr;
      rsp_err   <= cur_q.err;
      rsp_data  <= cur_q.err ? '0 : mem[rd_idx];
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
